imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate-generation stage for the decode pipeline. It extracts and sign- or zero-extends the immediate for every RV32I/RV64I format, plus CSR-uimm and shift-amount forms, to XLEN bits. Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush, so the stage runs at full throughput under ID/EX backpressure. It sits between instruction fetch/decode and the ID/EX register and carries an opaque tag, normally the PC, alongside each result.

## Interface
- `XLEN`, 32: datapath width. Legal values are 32 and 64.
- `TAG_W`, 32: width of the sideband tag carried with each instruction.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: the input beat is valid.
- `in_ready` output 1: the stage can accept a beat this cycle.
- `in_inst` input 32: raw instruction word.
- `in_imm_type` input 3: format code (see Operation).
- `in_tag` input TAG_W: sideband value, passed through unchanged.
- `out_valid` output 1: the head entry is valid.
- `out_ready` input 1: the consumer accepts the head entry this cycle.
- `out_imm` output XLEN: extended immediate of the head entry.
- `out_tag` output TAG_W: tag of the head entry.

## Operation
Format codes, with `i` meaning `in_inst`:
- 0 NONE: result is 0.
- 1 I: `sext(i[31:20])`.
- 2 S: `sext({i[31:25], i[11:7]})`.
- 3 SB: `sext({i[31], i[7], i[30:25], i[11:8], 0})`.
- 4 U: `{i[31:12], 12'b0}`, sign-extended to XLEN when XLEN=64.
- 5 UJ: `sext({i[31], i[19:12], i[20], i[30:21], 0})`.
- 6 Z: zero-extended `i[19:15]` (CSR uimm).
- 7 SH: zero-extended `i[25:20]` when XLEN=64, `i[24:20]` when XLEN=32.

Buffer behaviour:
- The buffer is a 2-entry FIFO of {imm, tag} with an occupancy count of 0..2.
- The immediate is computed combinationally at the input and written into the buffer. The output is the head entry only.
- A push occurs when `in_valid && in_ready`. A pop occurs when `out_valid && out_ready`.
- `in_ready = (count != 2)`. It is driven from registered state only, with no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- Push and pop in the same cycle at count 1: the count stays 1, and the new entry becomes head on the next cycle. Order is strictly FIFO.
- At count 2, `in_ready` is 0, so no push can occur. A pop drops the count to 1.
- `flush` has priority over everything: the count goes to 0 and any push in that cycle is discarded. `out_imm` and `out_tag` hold their last values, but they are don't-care while `out_valid` is 0.
- `in_imm_type` values outside 0..7 cannot occur because the field is 3 bits. Every code is defined above.

## Timing
- Reset values: count 0, `out_valid` 0, `in_ready` 1, `out_imm` 0, `out_tag` 0.
- Latency is 1 cycle. A beat accepted at edge N appears on `out_*` after edge N when the buffer was empty.
- Throughput is 1 beat per cycle when `out_ready` is held at 1.
- Reset asserted mid-operation drops all held entries immediately, without waiting for a clock edge.
- `out_imm` and `out_tag` stay stable while `out_valid && !out_ready`.

## Structure
- Package `imm_pkg` holds the eight format-code localparams (`IMM_NONE` .. `IMM_SH`) and the buffer depth constant (2). The decoder and control unit share these.
- Sub-module `imm_decode` (combinational, parameter XLEN) computes the immediate from `inst` and `imm_type`. The top level instantiates it once, ahead of the buffer.
- The top level holds the two storage slots, head and tail pointers, the count, and the handshake logic.

## Test plan
- Reset: assert `rst_n=0` mid-stream. Required: `out_valid=0`, `in_ready=1`, `out_imm=0` immediately, before any clock edge.
- Formats, XLEN=32, `out_ready=1`:
  - 0xFFF00093 type I → 0xFFFFFFFF.
  - 0xFE112E23 type S → 0xFFFFFFFC.
  - 0xFF9FF06F type UJ → 0xFFFFFFF8.
  - 0x800000B7 type U → 0x80000000.
  - Each result appears 1 cycle after acceptance.
- XLEN=64:
  - 0x800000B7 type U → 0xFFFFFFFF80000000.
  - 0x03F0D093 type SH → 0x3F.
  - 0x000FD073 type Z → 0x1F.
- Backpressure: hold `out_ready=0`, drive 3 back-to-back beats with tags 1, 2, 3. Required: `in_ready` falls after 2 accepts, and beat 3 is held. Then release `out_ready`. Required: tags emerge in order 1, 2, 3 with no gap.
- Simultaneous push/pop at count 1 over 10 cycles: count stays 1 and all 10 tags emerge in order.
- Flush at count 2 with `in_valid=1` in the same cycle: next cycle `out_valid=0`, `in_ready=1`, and the flushed beat never appears on the output.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: format codes and
// the output buffer geometry used by both the decoder and the top level.
package imm_pkg;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_SB   = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_UJ   = 3'd5;
    localparam logic [2:0] IMM_Z    = 3'd6;
    localparam logic [2:0] IMM_SH   = 3'd7;

    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for every RV32I/RV64I format plus the
// CSR-uimm and shift-amount forms, extended to XLEN bits.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_sb;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_uj;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Signed intermediates let a width cast perform the sign extension.
    assign imm_i  = inst[31:20];
    assign imm_s  = {inst[31:25], inst[11:7]};
    assign imm_sb = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_uj = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        // NOTE: default first so every path assigns imm and no latch is inferred.
        imm = '0;
        unique case (imm_type)
            IMM_NONE: imm = '0;
            IMM_I:    imm = XLEN'(imm_i);
            IMM_S:    imm = XLEN'(imm_s);
            IMM_SB:   imm = XLEN'(imm_sb);
            IMM_U:    imm = XLEN'(imm_u);
            IMM_UJ:   imm = XLEN'(imm_uj);
            IMM_Z:    imm = XLEN'(inst[19:15]);
            IMM_SH:   imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decodes the immediate at the input
// and holds {imm, tag} in a 2-entry skid buffer with valid/ready on both sides.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  slot_imm [BUF_DEPTH];
    logic [TAG_W-1:0] slot_tag [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst     (in_inst),
        .imm_type (in_imm_type),
        .imm      (dec_imm)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != CNT_W'(BUF_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_imm = slot_imm[head];
    assign out_tag = slot_tag[tail == head && count == '0 ? head : head];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            // Collapse to empty at the current head so the outputs hold their last values.
            tail  <= head;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage slots are reset because out_imm/out_tag must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                slot_imm[i] <= '0;
                slot_tag[i] <= '0;
            end
        end else if (push) begin
            slot_imm[tail] <= dec_imm;
            slot_tag[tail] <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// one stimulus stream and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int TAG_W = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [2:0]       in_imm_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, out_valid32;
    logic [31:0]      out_imm32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      imm32;
        logic [63:0]      imm64;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Immediate value from the format definitions, using integer arithmetic on the word.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input int t, input bit x64);
        longint s;
        longint v;
        s = longint'($signed(i));
        case (t)
            1: v = s >>> 20;
            2: v = ((s >>> 25) <<< 5) | longint'((i >> 7) & 32'h1F);
            3: v = ((s >>> 31) <<< 12) | longint'(((i >> 7) & 1) << 11)
                 | longint'(((i >> 25) & 32'h3F) << 5) | longint'(((i >> 8) & 32'hF) << 1);
            4: v = longint'($signed(i & 32'hFFFF_F000));
            5: v = ((s >>> 31) <<< 20) | longint'(((i >> 12) & 32'hFF) << 12)
                 | longint'(((i >> 20) & 1) << 11) | longint'(((i >> 21) & 32'h3FF) << 1);
            6: v = longint'((i >> 15) & 32'h1F);
            7: v = x64 ? longint'((i >> 20) & 32'h3F) : longint'((i >> 20) & 32'h1F);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic drive(input bit v, input logic [31:0] inst, input logic [2:0] t,
                         input logic [TAG_W-1:0] tag);
        in_valid    = v;
        in_inst     = inst;
        in_imm_type = t;
        in_tag      = tag;
    endtask

    // One clock: predict acceptance from pre-edge inputs, advance, then compare.
    task automatic tick();
        bit   do_flush, do_push, do_pop;
        exp_t e;
        logic [63:0] r32;
        do_flush = flush;
        do_push  = in_valid && (q.size() < 2);
        do_pop   = (q.size() > 0) && out_ready;
        r32      = ref_imm(in_inst, int'(in_imm_type), 1'b0);
        e.imm32  = r32[31:0];
        e.imm64  = ref_imm(in_inst, int'(in_imm_type), 1'b1);
        e.tag    = in_tag;
        @(posedge clk);
        #1;
        if (do_flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        check("in_ready32", 64'(in_ready32), 64'(q.size() != 2));
        check("in_ready64", 64'(in_ready64), 64'(q.size() != 2));
        check("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
        check("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_imm32", 64'(out_imm32), 64'(q[0].imm32));
            check("out_imm64", out_imm64, q[0].imm64);
            check("out_tag32", 64'(out_tag32), 64'(q[0].tag));
            check("out_tag64", 64'(out_tag64), 64'(q[0].tag));
        end
    endtask

    logic [31:0] vec_inst [7];
    logic [2:0]  vec_type [7];
    logic [63:0] vec_exp  [7];
    bit          vec_x64  [7];

    initial begin
        vec_inst = '{32'hFFF0_0093, 32'hFE11_2E23, 32'hFF9F_F06F, 32'h8000_00B7,
                     32'h8000_00B7, 32'h03F0_D093, 32'h000F_D073};
        vec_type = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd4, 3'd7, 3'd6};
        vec_exp  = '{64'hFFFF_FFFF, 64'hFFFF_FFFC, 64'hFFFF_FFF8, 64'h8000_0000,
                     64'hFFFF_FFFF_8000_0000, 64'h3F, 64'h1F};
        vec_x64  = '{0, 0, 0, 0, 1, 1, 1};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(0, '0, '0, '0);
        #1;
        check("reset out_valid", 64'(out_valid32), 64'd0);
        check("reset in_ready", 64'(in_ready32), 64'd1);
        check("reset out_imm", out_imm64, 64'd0);
        check("reset out_tag", 64'(out_tag32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed formats, back to back, each visible one cycle after acceptance.
        for (int k = 0; k < 7; k++) begin
            drive(1, vec_inst[k], vec_type[k], TAG_W'(k + 16));
            tick();
            if (vec_x64[k]) check($sformatf("fmt%0d x64", k), out_imm64, vec_exp[k]);
            else            check($sformatf("fmt%0d x32", k), 64'(out_imm32), vec_exp[k]);
        end
        drive(0, '0, '0, '0);
        tick();

        // Backpressure: two accepts fill the buffer, the third beat waits.
        out_ready = 1'b0;
        drive(1, $urandom, 3'($urandom_range(0, 7)), 1);
        tick();
        drive(1, $urandom, 3'($urandom_range(0, 7)), 2);
        tick();
        check("bp full in_ready", 64'(in_ready32), 64'd0);
        drive(1, $urandom, 3'($urandom_range(0, 7)), 3);
        tick();
        check("bp held in_ready", 64'(in_ready64), 64'd0);
        check("bp head tag", 64'(out_tag32), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp second tag", 64'(out_tag32), 64'd2);
        tick();
        check("bp third tag", 64'(out_tag32), 64'd3);
        drive(0, '0, '0, '0);
        tick();
        check("bp drained", 64'(out_valid32), 64'd0);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        drive(1, 32'hFFF0_0093, 3'd1, 32'hAA);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid32), 64'd0);
        check("async rst in_ready", 64'(in_ready64), 64'd1);
        check("async rst out_imm", 64'(out_imm32), 64'd0);
        q.delete();
        #1;
        rst_n = 1'b1;
        drive(0, '0, '0, '0);
        tick();

        // Push and pop together at occupancy 1 for ten cycles.
        drive(1, $urandom, 3'($urandom_range(0, 7)), 100);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1, $urandom, 3'($urandom_range(0, 7)), TAG_W'(101 + k));
            tick();
            check("pp tag", 64'(out_tag64), 64'(101 + k));
            check("pp in_ready", 64'(in_ready32), 64'd1);
        end
        drive(0, '0, '0, '0);
        tick();

        // Flush at full occupancy discards both entries and the concurrent beat.
        out_ready = 1'b0;
        drive(1, $urandom, 3'd4, 200);
        tick();
        drive(1, $urandom, 3'd4, 201);
        tick();
        flush = 1'b1;
        drive(1, $urandom, 3'd1, 32'hDEAD);
        tick();
        check("flush out_valid", 64'(out_valid32), 64'd0);
        check("flush in_ready", 64'(in_ready32), 64'd1);
        flush = 1'b0;
        drive(0, '0, '0, '0);
        tick();
        tick();
        out_ready = 1'b1;
        drive(1, $urandom, 3'd2, 202);
        tick();
        check("post flush tag", 64'(out_tag32), 64'd202);
        drive(0, '0, '0, '0);
        tick();

        // Randomised traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = $urandom_range(0, 3) != 0;
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
            tick();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
